// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with one outstanding memory request,
// a single-entry output slot toward decode, and redirect handling from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] fetch_count
);
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_WAIT  = 1'b1;

    logic [0:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        kill;
    logic        slot_fire;
    logic        resp_load;

    assign imem_req_valid = state == S_FETCH && !next_pc_valid && (!instruction_valid || instruction_ready);
    assign imem_req_addr  = fetch_pc;
    // a redirect flushes the slot, so a coincident ready is not a handshake
    assign slot_fire      = instruction_valid && instruction_ready && !next_pc_valid;
    assign resp_load      = state == S_WAIT && imem_resp_valid && !kill && !next_pc_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc          <= RESET_PC;
            req_pc            <= RESET_PC;
            state             <= S_FETCH;
            kill              <= 1'b0;
            instruction_valid <= 1'b0;
            instruction       <= 32'd0;
            pc                <= 32'd0;
            fetch_count       <= 32'd0;
        end else begin
            fetch_count <= fetch_count + {31'd0, slot_fire};
            if (resp_load) begin
                instruction       <= imem_resp_data;
                pc                <= req_pc;
                instruction_valid <= 1'b1;
            end else if (slot_fire || next_pc_valid) begin
                instruction_valid <= 1'b0;
            end
            if (next_pc_valid)
                fetch_pc <= {next_pc[31:2], 2'b00};
            else if (resp_load)
                fetch_pc <= req_pc + 32'(PC_STEP);
            if (state == S_FETCH) begin
                if (imem_req_valid && imem_req_ready) begin
                    req_pc <= fetch_pc;
                    state  <= S_WAIT;
                end
            end else if (imem_resp_valid) begin
                kill  <= 1'b0;
                state <= S_FETCH;
            end else if (next_pc_valid) begin
                kill <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a
// stream-level model of expected request addresses and delivered (pc, word) pairs.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        next_pc_valid = 1'b0;
    logic [31:0] next_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        instruction_valid;
    logic        instruction_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clock(clock), .reset(reset),
        .next_pc_valid(next_pc_valid), .next_pc(next_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
        .instruction(instruction), .pc(pc), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, npv;
        logic [31:0] npc;
        logic        rq_rdy, rs_vld;
        logic [31:0] rs_data;
        logic        in_rdy, chk;
        logic        e_rq_vld;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc, e_ins, e_cnt;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    vec_t v[29];

    initial begin
        logic [31:0] m_pc, m_req, m_cnt, pend_addr, hs, prev_pc, prev_ins;
        logic        outstanding, rst, npv, rv, rq_rdy, in_rdy, prev_hold;
        logic [31:0] npc;
        int          cnt_down;
        //        rst npv npc           rqr rsv data          inr chk  erv eaddr         eiv epc           eins     ecnt
        v[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,        32'h0,  0};
        v[1]  = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h0,        0, 32'h0,        32'h0,  0};
        v[2]  = '{0, 0, 32'h0,        1, 1, 32'h11,       1, 1,   0, 32'h0,        0, 32'h0,        32'h0,  0};
        v[3]  = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h4,        1, 32'h0,        32'h11, 0};
        v[4]  = '{0, 0, 32'h0,        1, 1, 32'h22,       1, 1,   0, 32'h4,        0, 32'h0,        32'h11, 1};
        v[5]  = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h8,        1, 32'h4,        32'h22, 1};
        v[6]  = '{0, 0, 32'h0,        1, 1, 32'h33,       1, 1,   0, 32'h8,        0, 32'h4,        32'h22, 2};
        v[7]  = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 1,   0, 32'hC,        1, 32'h8,        32'h33, 2};
        v[8]  = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 1,   0, 32'hC,        1, 32'h8,        32'h33, 2};
        v[9]  = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'hC,        1, 32'h8,        32'h33, 2};
        v[10] = '{0, 1, 32'h203,      1, 0, 32'h0,        1, 1,   0, 32'hC,        0, 32'h8,        32'h33, 3};
        v[11] = '{0, 0, 32'h0,        1, 1, 32'hDEAD,     1, 1,   0, 32'h200,      0, 32'h8,        32'h33, 3};
        v[12] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h200,      0, 32'h8,        32'h33, 3};
        v[13] = '{0, 0, 32'h0,        1, 1, 32'h44,       1, 1,   0, 32'h200,      0, 32'h8,        32'h33, 3};
        v[14] = '{0, 1, 32'h100,      1, 0, 32'h0,        1, 1,   0, 32'h204,      1, 32'h200,      32'h44, 3};
        v[15] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h100,      0, 32'h200,      32'h44, 3};
        v[16] = '{0, 1, 32'h300,      1, 1, 32'h55,       1, 1,   0, 32'h100,      0, 32'h200,      32'h44, 3};
        v[17] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h300,      0, 32'h200,      32'h44, 3};
        v[18] = '{0, 0, 32'h0,        1, 1, 32'h66,       1, 1,   0, 32'h300,      0, 32'h200,      32'h44, 3};
        v[19] = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 1,   0, 32'h304,      1, 32'h300,      32'h66, 3};
        v[20] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h304,      1, 32'h300,      32'h66, 3};
        v[21] = '{1, 0, 32'h0,        1, 0, 32'h0,        1, 1,   0, 32'h304,      0, 32'h300,      32'h66, 4};
        v[22] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1,   1, 32'h0,        0, 32'h0,        32'h0,  0};
        v[23] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h0,        0, 32'h0,        32'h0,  0};
        v[24] = '{0, 1, 32'hFFFF_FFFF, 1, 1, 32'h77,      1, 1,   0, 32'h0,        0, 32'h0,        32'h0,  0};
        v[25] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,  0};
        v[26] = '{0, 0, 32'h0,        1, 1, 32'h88,       1, 1,   0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,  0};
        v[27] = '{0, 0, 32'h0,        1, 0, 32'h0,        1, 1,   1, 32'h0,        1, 32'hFFFF_FFFC, 32'h88, 0};
        v[28] = '{1, 0, 32'h0,        1, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'hFFFF_FFFC, 32'h88, 1};
        for (int i = 0; i < 29; i++) begin
            @(negedge clock);
            reset = v[i].rst; next_pc_valid = v[i].npv; next_pc = v[i].npc;
            imem_req_ready = v[i].rq_rdy; imem_resp_valid = v[i].rs_vld; imem_resp_data = v[i].rs_data;
            instruction_ready = v[i].in_rdy;
            #1;
            if (v[i].chk) begin
                tests++;
                if (imem_req_valid !== v[i].e_rq_vld || imem_req_addr !== v[i].e_addr ||
                    instruction_valid !== v[i].e_iv || pc !== v[i].e_pc ||
                    instruction !== v[i].e_ins || fetch_count !== v[i].e_cnt) begin
                    fails++;
                    $display("FAIL vec%0d: got rqv=%b addr=%h iv=%b pc=%h ins=%h cnt=%0d expected rqv=%b addr=%h iv=%b pc=%h ins=%h cnt=%0d",
                             i, imem_req_valid, imem_req_addr, instruction_valid, pc, instruction, fetch_count,
                             v[i].e_rq_vld, v[i].e_addr, v[i].e_iv, v[i].e_pc, v[i].e_ins, v[i].e_cnt);
                end
            end
        end
        // randomized phase: reset state carried over from the last table row
        m_pc = 0; m_req = 0; m_cnt = 0; hs = 0; outstanding = 0; cnt_down = 0;
        pend_addr = 0; prev_hold = 0; prev_pc = 0; prev_ins = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            check("fetch_count", fetch_count, m_cnt);
            rst = $urandom_range(0, 499) == 0;
            npv = $urandom_range(0, 19) == 0;
            npc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            rq_rdy = $urandom_range(0, 3) != 0;
            in_rdy = $urandom_range(0, 9) < 7;
            rv = 1'b0;
            if (outstanding) begin
                cnt_down--;
                rv = cnt_down == 0;
            end
            if (rst) begin
                rv = 1'b0;
                outstanding = 1'b0;
            end
            reset = rst; next_pc_valid = npv; next_pc = npc;
            imem_req_ready = rq_rdy; instruction_ready = in_rdy;
            imem_resp_valid = rv; imem_resp_data = rv ? mem_word(pend_addr) : $urandom;
            #1;
            if (!rst) begin
                if (prev_hold) begin
                    check("hold_valid", {31'd0, instruction_valid}, 32'd1);
                    check("hold_pc", pc, prev_pc);
                    check("hold_ins", instruction, prev_ins);
                end
                if (imem_req_valid)
                    check("req_legal", {31'd0, outstanding || npv}, 32'd0);
                if (rv) outstanding = 1'b0;
                if (instruction_valid && in_rdy && !npv) begin
                    check("deliver_pc", pc, m_pc);
                    check("deliver_ins", instruction, mem_word(m_pc));
                    m_pc += 32'd4;
                    m_cnt++;
                    hs++;
                end
                if (imem_req_valid && rq_rdy) begin
                    check("req_addr", imem_req_addr, m_req);
                    m_req = imem_req_addr + 32'd4;
                    pend_addr = imem_req_addr;
                    outstanding = 1'b1;
                    cnt_down = $urandom_range(1, 4);
                end
                if (npv) begin
                    m_pc = {npc[31:2], 2'b00};
                    m_req = m_pc;
                end
            end else begin
                m_pc = 0; m_req = 0; m_cnt = 0;
            end
            prev_hold = !rst && instruction_valid && !in_rdy && !npv;
            prev_pc = pc;
            prev_ins = instruction;
        end
        check("progress", {31'd0, hs > 200}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
